aud_dsp: RTL

//  Playback sample engine downstream of the recorder's SRAM image. Walks the recorded address

---
 rtl/aud_dsp_if.sv | 24 ++
 rtl/aud_dsp.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_dsp_if.sv
`default_nettype none
// aud_dsp_if: SRAM read port plus DAC serializer handshake for the playback engine.
interface aud_dsp_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] i_sram_data;
  logic              i_daclrck;
  logic [DATA_W-1:0] o_dac_data;
  logic              o_player_en;
  logic              o_done;

  modport master (
    output o_sram_addr, o_dac_data, o_player_en, o_done,
    input  i_sram_data, i_daclrck
  );

  modport slave (
    input  o_sram_addr, o_dac_data, o_player_en, o_done,
    output i_sram_data, i_daclrck
  );
endinterface
`default_nettype wire

// File: rtl/aud_dsp.sv
`default_nettype none
// aud_dsp: SRAM playback engine with speed control (skip / hold / linear interpolation) feeding the I2S DAC.
// Build option: define AUD_DSP_REVERSE_EN to add i_reverse (backwards playback from i_end_addr).
module aud_dsp #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int SPEED_W = 3
) (
  input  wire logic               i_clk,
  input  wire logic               i_rst_n,
  input  wire logic               i_start,
  input  wire logic               i_pause,
  input  wire logic               i_stop,
  input  wire logic               i_fast,
  input  wire logic               i_slow_0,
  input  wire logic               i_slow_1,
  input  wire logic [SPEED_W-1:0] i_speed,
  input  wire logic [ADDR_W-1:0]  i_end_addr,
`ifdef AUD_DSP_REVERSE_EN
  input  wire logic               i_reverse,
`endif
  aud_dsp_if.master               bus
);
  localparam int NW = SPEED_W + 1;
  localparam int PW = DATA_W + SPEED_W + 2;
  localparam int XW = PW + 18;

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSED, S_WAIT, S_FETCH0, S_FETCH1, S_CALC, S_PLAY
  } state_t;
  typedef enum logic [1:0] {M_NORM, M_SLOW0, M_SLOW1, M_FAST} mode_t;

  state_t              r_state, w_state_nxt;
  mode_t               r_mode, w_mode_nxt, w_mode_sel;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt, r_sram_addr, w_sram_nxt;
  logic [ADDR_W-1:0]   w_home, w_home_start, w_nbr_addr, w_addr_adv;
  logic [SPEED_W-1:0]  r_frac, w_frac_nxt, w_frac_adv, r_speed, w_speed_nxt;
  logic [NW-1:0]       r_n, w_n_nxt, w_n_sel, w_step, w_c0, w_c1;
  logic [DATA_W-1:0]   r_s0, w_s0_nxt, r_s1, w_s1_nxt, r_dac, w_dac_nxt, w_interp;
  logic                r_en, w_en_nxt, r_done, w_done_nxt, r_last, w_last_nxt;
  logic                r_lrc, r_lrc_d, w_rise, w_fall;
  logic                w_slow, w_wrap, w_past, w_rev, w_rev_start;
  logic [ADDR_W:0]     w_fwd, w_step_x;
  logic signed [PW-1:0] w_s0x, w_s1x, w_c0x, w_c1x, w_wsum;
  logic signed [XW-1:0] w_wx, w_rx, w_scaled;
  logic [16:0]         w_recip;

`ifdef AUD_DSP_REVERSE_EN
  logic r_rev;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_rev <= 1'b0;
    else if (r_state == S_IDLE && i_start && !i_stop && !i_pause)
      r_rev <= i_reverse;
  end
  assign w_rev       = r_rev;
  assign w_rev_start = i_reverse;
`else
  assign w_rev       = 1'b0;
  assign w_rev_start = 1'b0;
`endif

  assign w_rise       = r_lrc & ~r_lrc_d;
  assign w_fall       = ~r_lrc & r_lrc_d;
  assign w_home       = w_rev ? i_end_addr : '0;
  assign w_home_start = w_rev_start ? i_end_addr : '0;

  always_comb begin
    w_mode_sel = M_NORM;
    w_n_sel    = NW'(1);
    if (i_fast) begin
      w_mode_sel = M_FAST;
      w_n_sel    = {1'b0, i_speed} + NW'(1);
    end else if (i_slow_1) begin
      w_mode_sel = M_SLOW1;
      w_n_sel    = {1'b0, i_speed} + NW'(1);
    end else if (i_slow_0) begin
      w_mode_sel = M_SLOW0;
      w_n_sel    = {1'b0, i_speed} + NW'(1);
    end
  end

  // Slow modes step the address only when the hold/interpolation phase wraps.
  assign w_slow     = (r_mode == M_SLOW0) || (r_mode == M_SLOW1);
  assign w_wrap     = ({1'b0, r_frac} == (r_n - NW'(1)));
  assign w_step     = w_slow ? (w_wrap ? NW'(1) : '0) : r_n;
  assign w_frac_adv = (w_slow && !w_wrap) ? r_frac + SPEED_W'(1) : '0;
  assign w_step_x   = {{(ADDR_W + 1 - NW){1'b0}}, w_step};
  assign w_fwd      = {1'b0, r_addr} + w_step_x;
  assign w_past     = w_rev ? (w_step_x > {1'b0, r_addr}) : (w_fwd > {1'b0, i_end_addr});
  assign w_addr_adv = w_rev ? (r_addr - w_step_x[ADDR_W-1:0]) : w_fwd[ADDR_W-1:0];
  assign w_nbr_addr = w_rev ? ((r_addr == '0) ? r_addr : r_addr - ADDR_W'(1))
                            : ((r_addr >= i_end_addr) ? r_addr : r_addr + ADDR_W'(1));

  always_comb begin
    case (r_n)
      NW'(2):  w_recip = 17'd32768;
      NW'(3):  w_recip = 17'd21846;
      NW'(4):  w_recip = 17'd16384;
      NW'(5):  w_recip = 17'd13108;
      NW'(6):  w_recip = 17'd10923;
      NW'(7):  w_recip = 17'd9363;
      NW'(8):  w_recip = 17'd8192;
      default: w_recip = 17'd65536;
    endcase
  end

  // Weighted sum scaled by a fixed-point reciprocal of N; the >>>16 floors toward -inf.
  assign w_c1     = {1'b0, r_frac};
  assign w_c0     = r_n - w_c1;
  assign w_s0x    = {{(PW - DATA_W){r_s0[DATA_W-1]}}, r_s0};
  assign w_s1x    = {{(PW - DATA_W){r_s1[DATA_W-1]}}, r_s1};
  assign w_c0x    = {{(PW - NW){1'b0}}, w_c0};
  assign w_c1x    = {{(PW - NW){1'b0}}, w_c1};
  assign w_wsum   = w_s0x * w_c0x + w_s1x * w_c1x;
  assign w_wx     = {{(XW - PW){w_wsum[PW-1]}}, w_wsum};
  assign w_rx     = {{(XW - 17){1'b0}}, w_recip};
  assign w_scaled = w_wx * w_rx;
  assign w_interp = DATA_W'(w_scaled >>> 16);

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_addr_nxt  = r_addr;
    w_sram_nxt  = r_sram_addr;
    w_frac_nxt  = r_frac;
    w_speed_nxt = r_speed;
    w_n_nxt     = r_n;
    w_s0_nxt    = r_s0;
    w_s1_nxt    = r_s1;
    w_dac_nxt   = r_dac;
    w_en_nxt    = r_en;
    w_done_nxt  = 1'b0;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_state_nxt = S_WAIT;
        w_addr_nxt  = w_home_start;
        w_frac_nxt  = '0;
        w_last_nxt  = 1'b0;
      end
      S_PAUSED: if (i_start) w_state_nxt = S_WAIT;
      S_WAIT: if (w_rise) begin
        w_state_nxt = S_FETCH0;
        w_sram_nxt  = r_addr;
      end
      S_FETCH0: begin
        w_s0_nxt    = bus.i_sram_data;
        w_s1_nxt    = bus.i_sram_data;
        w_mode_nxt  = w_mode_sel;
        w_speed_nxt = i_speed;
        w_n_nxt     = w_n_sel;
        if (w_mode_sel != r_mode || i_speed != r_speed) w_frac_nxt = '0;
        if (w_mode_sel == M_SLOW1) begin
          w_state_nxt = S_FETCH1;
          w_sram_nxt  = w_nbr_addr;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_FETCH1: begin
        w_s1_nxt    = bus.i_sram_data;
        w_state_nxt = S_CALC;
      end
      S_CALC: begin
        w_dac_nxt   = (r_mode == M_SLOW1) ? w_interp : r_s0;
        w_frac_nxt  = w_frac_adv;
        w_state_nxt = S_PLAY;
        if (w_past) w_last_nxt = 1'b1;
        else        w_addr_nxt = w_addr_adv;
      end
      S_PLAY: begin
        if (w_rise) begin
          w_en_nxt = 1'b0;
          if (r_last) begin
            w_done_nxt  = 1'b1;
            w_addr_nxt  = w_home;
            w_frac_nxt  = '0;
            w_last_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_sram_nxt  = r_addr;
            w_state_nxt = S_FETCH0;
          end
        end else if (w_fall) begin
          w_en_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (i_stop) begin
      w_state_nxt = S_IDLE;
      w_addr_nxt  = w_home;
      w_frac_nxt  = '0;
      w_dac_nxt   = '0;
      w_en_nxt    = 1'b0;
      w_done_nxt  = 1'b0;
      w_last_nxt  = 1'b0;
    end else if (i_pause) begin
      // Pausing an idle player just swallows any coincident start.
      w_state_nxt = (r_state == S_IDLE) ? S_IDLE : S_PAUSED;
      w_addr_nxt  = r_addr;
      w_frac_nxt  = r_frac;
      w_dac_nxt   = '0;
      w_en_nxt    = 1'b0;
      w_done_nxt  = 1'b0;
      w_last_nxt  = r_last;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= M_NORM;
      r_addr      <= '0;
      r_sram_addr <= '0;
      r_frac      <= '0;
      r_speed     <= '0;
      r_n         <= NW'(1);
      r_s0        <= '0;
      r_s1        <= '0;
      r_dac       <= '0;
      r_en        <= 1'b0;
      r_done      <= 1'b0;
      r_last      <= 1'b0;
      r_lrc       <= 1'b0;
      r_lrc_d     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_addr      <= w_addr_nxt;
      r_sram_addr <= w_sram_nxt;
      r_frac      <= w_frac_nxt;
      r_speed     <= w_speed_nxt;
      r_n         <= w_n_nxt;
      r_s0        <= w_s0_nxt;
      r_s1        <= w_s1_nxt;
      r_dac       <= w_dac_nxt;
      r_en        <= w_en_nxt;
      r_done      <= w_done_nxt;
      r_last      <= w_last_nxt;
      r_lrc       <= bus.i_daclrck;
      r_lrc_d     <= r_lrc;
    end
  end

  assign bus.o_sram_addr = r_sram_addr;
  assign bus.o_dac_data  = r_dac;
  assign bus.o_player_en = r_en;
  assign bus.o_done      = r_done;
endmodule
`default_nettype wire
